xbar_slave_arbiter: RTL
=======================

Name: xbar_slave_arbiter

Overview:
Per-slave-port round-robin scheduler for the 2x2 crossbar. It picks one of two masters whose address targets this slave and forwards that master's cmd/addr/wdata to the slave. It routes the slave's ack, and for reads the rdata, back to the granted master only. One instance is built per slave port, replacing the combinational req/ack arbiter pair and the data-return logic for that port with a single FSM.

Parameters:
SLAVE_ID, 0, value of addr[31] that selects this slave (0 or 1)
AW, 32, address width
DW, 32, data width
STALL_LIMIT, 255, wait cycles in GRANT without s_ack before stall_err is set (8-bit counter)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
m0_req  in  1  master 0 request, held until its ack
m0_cmd  in  1  0=read, 1=write
m0_addr  in  AW  master 0 address; bit AW-1 selects slave
m0_wdata  in  DW  master 0 write data
m0_ack  out  1  ack routed to master 0
m0_rdata  out  DW  read data routed to master 0
m1_req/m1_cmd/m1_addr/m1_wdata  in  1/1/AW/DW  master 1, same meaning as master 0
m1_ack/m1_rdata  out  1/DW  master 1, same meaning as master 0
s_req  out  1  request to slave
s_cmd  out  1  forwarded cmd
s_addr  out  AW  forwarded address
s_wdata  out  DW  forwarded write data
s_ack  in  1  slave accepted the request
s_rdata  in  DW  read data, valid the cycle after s_ack of a read
grant  out  1  index of the currently/last granted master
stall_err  out  1  sticky, set when the stall counter reaches STALL_LIMIT

Behaviour:
- Eligibility: elig_i = mi_req && (mi_addr[AW-1] == SLAVE_ID).
- FSM states: IDLE, GRANT, RDATA. Reset: state=IDLE, last=1 (so master 0 wins the first tie), grant=0, stall counter=0, stall_err=0.
- IDLE:
  - If only one master is eligible, register grant to that master.
  - If both are eligible, grant = ~last.
  - Latch the granted master's cmd into cmd_q, then go to GRANT.
  - If no master is eligible, stay in IDLE.
- GRANT:
  - s_req=1. s_cmd/s_addr/s_wdata are muxed combinationally from the granted master's live inputs; the master holds them stable until its ack.
  - On s_ack=1: m[grant]_ack=s_ack in the same cycle (combinational), last<=grant, counter<=0.
  - Next state after ack: RDATA if cmd_q==0, IDLE if cmd_q==1.
- RDATA: m[grant]_rdata=s_rdata for exactly one cycle, s_req=0, then go to IDLE.
- Outputs outside the active path:
  - Non-granted ack and rdata are 0 at all times.
  - All rdata is 0 outside RDATA.
  - s_req=0 and s_cmd/s_addr/s_wdata=0 outside GRANT.
- Latency and throughput:
  - Request seen at cycle t -> s_req at t+1.
  - Minimum write turnaround is 2 cycles. Minimum read turnaround is 3 cycles, with rdata at ack+1.
  - A new grant can be issued only from IDLE; no back-to-back grants without passing through IDLE.
- Fairness: under continuous requests from both masters, grants strictly alternate 0,1,0,1.
- A master's request that targets the other slave is ignored entirely by this instance.
- Stall counter:
  - Increments every GRANT cycle with s_ack=0 and saturates at STALL_LIMIT.
  - When it equals STALL_LIMIT, stall_err<=1. stall_err clears only on rst.
  - The request is never abandoned.
- s_ack outside GRANT is ignored: no ack is routed and no state change occurs.
- A master dropping req while in GRANT is a protocol violation and is not checked; the FSM keeps waiting for s_ack.
- Reset asserted in any state returns every register to its reset value on the next edge. No ack or rdata is produced in the cycle after reset.

Decomposition:
- Shared package/header xbar_defs: CMD_READ=0, CMD_WRITE=1, FSM state encodings (IDLE=2'd0, GRANT=2'd1, RDATA=2'd2), and the default AW/DW.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker taking elig0, elig1 and last, and producing valid and idx. It is reusable by future master-side schedulers.

Test Plan:
- Single write: m0 req, cmd=1, addr=0x0000_0010, wdata=0xA5A5_A5A5 at t0; s_ack at t2 -> s_req=1 at t1..t2, s_addr=0x10, s_wdata=0xA5A5_A5A5, m0_ack=1 at t2 only, m1_ack=0, back in IDLE at t3.
- Read return: SLAVE_ID=1, m1 reads addr 0x8000_0004; s_ack at t1, s_rdata=0xDEAD_BEEF at t2 -> m1_rdata=0xDEAD_BEEF at t2 only; m0_rdata=0 throughout.
- Contention: both masters continuously write to this slave, slave acks immediately -> grant sequence is 0,1,0,1 starting with master 0 after reset; each master gets 2 acks in 4 transactions.
- Address filter: SLAVE_ID=0, m0 addr=0x8000_0000, m1 addr=0x0000_0000 simultaneously -> only m1 is granted; m0 never acked by this instance.
- Stall: STALL_LIMIT=4, s_ack held 0 -> stall_err rises after 4 GRANT cycles and stays 1 after a later s_ack; rst clears it to 0.
- Reset mid-read: rst asserted in RDATA -> next cycle state=IDLE, s_req=0, all acks and rdata 0, and master 0 wins the next tie.

Source files
------------

// File: rtl/xbar_defs.sv
// Shared crossbar definitions: command encoding, slave-arbiter FSM states, default widths.
package xbar_defs;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RDATA = 2'd2
    } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the master that did not win last time wins.
module rr_pick2 (
    input  logic i_elig0,
    input  logic i_elig1,
    input  logic i_last,
    output logic o_valid,
    output logic o_idx
);

    // Single requester wins outright; a tie goes to the opposite of the last winner.
    always_comb begin
        o_valid = i_elig0 | i_elig1;
        o_idx   = (i_elig0 & i_elig1) ? ~i_last : i_elig1;
    end

endmodule

// File: rtl/xbar_slave_arbiter.sv
// Per-slave-port scheduler for the 2x2 crossbar: picks one of two masters, forwards its
// request to the slave, and routes ack/rdata back to the granted master only.
module xbar_slave_arbiter
    import xbar_defs::*;
#(
    parameter int unsigned SLAVE_ID    = 0,
    parameter int unsigned AW          = DEF_AW,
    parameter int unsigned DW          = DEF_DW,
    parameter int unsigned STALL_LIMIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_cmd,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_cmd,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          s_req,
    output logic          s_cmd,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_ack,
    input  logic [DW-1:0] s_rdata,
    output logic          grant,
    output logic          stall_err
);

    localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

    state_e     r_state;
    state_e     w_state_d;
    logic       r_last;
    logic       r_grant;
    logic       r_cmd;
    logic [7:0] r_cnt;
    logic       r_stall_err;

    logic       w_elig0;
    logic       w_elig1;
    logic       w_pick_valid;
    logic       w_pick_idx;
    logic [7:0] w_cnt_inc;

    // A request aimed at the other slave is invisible to this instance.
    assign w_elig0 = m0_req && (m0_addr[AW-1] == 1'(SLAVE_ID));
    assign w_elig1 = m1_req && (m1_addr[AW-1] == 1'(SLAVE_ID));

    // Saturating increment of the stall counter.
    assign w_cnt_inc = (r_cnt == LIMIT) ? r_cnt : r_cnt + 8'd1;

    assign grant     = r_grant;
    assign stall_err = r_stall_err;

    rr_pick2 u_pick (
        .i_elig0 (w_elig0),
        .i_elig1 (w_elig1),
        .i_last  (r_last),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Next-state and output decode; everything idles at zero unless on the active path.
    always_comb begin
        w_state_d = r_state;
        s_req     = 1'b0;
        s_cmd     = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_d = GRANT;
                end
            end
            GRANT: begin
                s_req   = 1'b1;
                s_cmd   = r_grant ? m1_cmd   : m0_cmd;
                s_addr  = r_grant ? m1_addr  : m0_addr;
                s_wdata = r_grant ? m1_wdata : m0_wdata;
                if (s_ack) begin
                    m0_ack    = ~r_grant;
                    m1_ack    = r_grant;
                    w_state_d = (r_cmd == CMD_WRITE) ? IDLE : RDATA;
                end
            end
            RDATA: begin
                m0_rdata  = r_grant ? '0 : s_rdata;
                m1_rdata  = r_grant ? s_rdata : '0;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and stall tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_cmd       <= CMD_READ;
            r_cnt       <= 8'd0;
            r_stall_err <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (r_state == IDLE && w_pick_valid) begin
                r_grant <= w_pick_idx;
                r_cmd   <= w_pick_idx ? m1_cmd : m0_cmd;
            end
            if (r_state == GRANT) begin
                if (s_ack) begin
                    r_last <= r_grant;
                    r_cnt  <= 8'd0;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == LIMIT) begin
                        r_stall_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
